// File: rtl/regfile_vec_banked.sv
// Vector register file: per-lane masked writes, same-cycle write-to-read bypass,
// out-of-window address protection and a multi-cycle bulk-clear sequencer.
module regfile_vec_banked #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned LANE_W = 32,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned BASE   = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vwe3,
  input  logic [ADDR_W-1:0]         vwa3,
  input  logic [LANES*LANE_W-1:0]   vwd3,
  input  logic [LANES-1:0]          vwmask,
  input  logic [ADDR_W-1:0]         vra1,
  input  logic [ADDR_W-1:0]         vra2,
  output logic [LANES*LANE_W-1:0]   vrd1,
  output logic [LANES*LANE_W-1:0]   vrd2,
  input  logic                      clr_req,
  output logic                      clr_busy,
  output logic                      clr_done,
  output logic                      wr_drop
);

  localparam int unsigned VW    = LANES * LANE_W;
  localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_drop_q, wr_drop_d;
  logic [VW-1:0]    mem_q [NREGS];
  logic [VW-1:0]    mem_d [NREGS];

  logic             wr_en;
  logic [IDX_W-1:0] wr_row;
  logic [VW-1:0]    wr_merged;
  logic [VW-1:0]    rd1, rd2;

  // Register 0 is architecturally hardwired, so it is never in the window.
  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return (a != '0) && (32'(a) >= BASE) && (32'(a) < BASE + NREGS);
  endfunction

  function automatic logic [IDX_W-1:0] addr_row(input logic [ADDR_W-1:0] a);
    return IDX_W'(32'(a) - BASE);
  endfunction

  assign wr_en  = vwe3 && addr_valid(vwa3) && (state_q == ST_IDLE);
  assign wr_row = addr_row(vwa3);

  // The merged row feeds both the storage update and the bypass path.
  always_comb begin
    wr_merged = mem_q[wr_row];
    for (int i = 0; i < LANES; i++) begin
      if (vwmask[i]) wr_merged[i*LANE_W +: LANE_W] = vwd3[i*LANE_W +: LANE_W];
    end
  end

  function automatic logic [VW-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [VW-1:0] v;
    v = '0;
    if (addr_valid(ra)) begin
      v = mem_q[addr_row(ra)];
      if (wr_en && (vwa3 == ra)) v = wr_merged;
    end
    return v;
  endfunction

  always_comb begin
    rd1 = read_port(vra1);
    rd2 = read_port(vra2);
  end

  // Reads are forced to zero while reset is held so bypass cannot leak data.
  assign vrd1    = rst ? rd1 : '0;
  assign vrd2    = rst ? rd2 : '0;
  assign wr_drop = wr_drop_q;

  // NOTE: every signal written here gets a default first; otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mem_d     = mem_q;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    wr_drop_d = vwe3 && (!addr_valid(vwa3) || (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (wr_en) mem_d[wr_row] = wr_merged;
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_busy      = 1'b1;
        mem_d[idx_q]  = '0;
        idx_d         = idx_q + 1'b1;
        if (idx_q == IDX_W'(NREGS - 1)) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end
      end
      ST_DONE: begin
        clr_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the storage array is reset too, because reads after reset must
  // return zero; a reset-less array would come up holding X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      wr_drop_q <= 1'b0;
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_drop_q <= wr_drop_d;
      for (int r = 0; r < NREGS; r++) mem_q[r] <= mem_d[r];
    end
  end

endmodule

// File: tb/tb_regfile_vec_banked.sv
// Scoreboard bench for regfile_vec_banked: default instance plus a small
// re-parameterised instance (4 lanes x 16 bits, 4 registers at base 8).
module tb_regfile_vec_banked;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance
  logic         vwe3, clr_req;
  logic [4:0]   vwa3, vra1, vra2;
  logic [255:0] vwd3, vrd1, vrd2;
  logic [7:0]   vwmask;
  logic         clr_busy, clr_done, wr_drop;

  // Small instance
  logic         b_we, b_clr;
  logic [4:0]   b_wa, b_ra1, b_ra2;
  logic [63:0]  b_wd, b_rd1, b_rd2;
  logic [3:0]   b_mask;
  logic         b_busy, b_done, b_drop;

  regfile_vec_banked dut_a (
    .clk(clk), .rst(rst), .vwe3(vwe3), .vwa3(vwa3), .vwd3(vwd3), .vwmask(vwmask),
    .vra1(vra1), .vra2(vra2), .vrd1(vrd1), .vrd2(vrd2), .clr_req(clr_req),
    .clr_busy(clr_busy), .clr_done(clr_done), .wr_drop(wr_drop)
  );

  regfile_vec_banked #(.LANES(4), .LANE_W(16), .NREGS(4), .BASE(8), .ADDR_W(5)) dut_b (
    .clk(clk), .rst(rst), .vwe3(b_we), .vwa3(b_wa), .vwd3(b_wd), .vwmask(b_mask),
    .vra1(b_ra1), .vra2(b_ra2), .vrd1(b_rd1), .vrd2(b_rd2), .clr_req(b_clr),
    .clr_busy(b_busy), .clr_done(b_done), .wr_drop(b_drop)
  );

  typedef enum {RD1, RD2, BUSY, DONE, DROP, B_RD1, B_RD2, B_BUSY, B_DONE, B_DROP} sig_e;
  typedef struct {
    sig_e         sig;
    string        tag;
    logic [255:0] val;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           now = 0;
  logic [255:0] m_a [8];

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] actual(input sig_e s);
    case (s)
      RD1:     return vrd1;
      RD2:     return vrd2;
      BUSY:    return 256'(clr_busy);
      DONE:    return 256'(clr_done);
      DROP:    return 256'(wr_drop);
      B_RD1:   return 256'(b_rd1);
      B_RD2:   return 256'(b_rd2);
      B_BUSY:  return 256'(b_busy);
      B_DONE:  return 256'(b_done);
      default: return 256'(b_drop);
    endcase
  endfunction

  task automatic expect_at(input sig_e s, input string tag, input logic [255:0] v, input int delay);
    exp_t e;
    e.sig = s; e.tag = tag; e.val = v; e.due = now + delay;
    exp_q.push_back(e);
  endtask

  task automatic score();
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due <= now) begin
        check(exp_q[i].tag, actual(exp_q[i].sig), exp_q[i].val);
        exp_q.delete(i);
      end
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    now++;
    #1;
  endtask

  task automatic tick();
    #1;
    score();
    next_edge();
  endtask

  task automatic idle_a();
    vwe3 = 1'b0; vwa3 = '0; vwd3 = '0; vwmask = '0; vra1 = '0; vra2 = '0; clr_req = 1'b0;
  endtask

  task automatic idle_b();
    b_we = 1'b0; b_wa = '0; b_wd = '0; b_mask = '0; b_ra1 = '0; b_ra2 = '0; b_clr = 1'b0;
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [255:0] d, input logic [7:0] m);
    vwe3 = 1'b1; vwa3 = a; vwd3 = d; vwmask = m;
  endtask

  task automatic wr_b(input logic [4:0] a, input logic [63:0] d, input logic [3:0] m);
    b_we = 1'b1; b_wa = a; b_wd = d; b_mask = m;
  endtask

  function automatic logic [255:0] fill(input int r);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'hA000_0000 | 32'(r << 8) | 32'(i);
    return v;
  endfunction

  initial begin
    logic [255:0] d17, upd17;
    rst = 1'b0;
    idle_a();
    idle_b();
    for (int r = 0; r < 8; r++) m_a[r] = '0;

    // Reset state
    #12;
    vra1 = 5'd16; vra2 = 5'd23;
    expect_at(RD1, "rst_rd16", '0, 0);
    expect_at(RD2, "rst_rd23", '0, 0);
    expect_at(BUSY, "rst_busy", '0, 0);
    expect_at(DONE, "rst_done", '0, 0);
    expect_at(DROP, "rst_drop", '0, 0);
    #1 score();
    #9 rst = 1'b1;
    next_edge();

    // Full write to 17, then read back on both ports
    for (int i = 0; i < 8; i++) d17[i*32 +: 32] = 32'h1111_1111 * i;
    wr_a(5'd17, d17, 8'hFF);
    expect_at(DROP, "wr17_nodrop", '0, 1);
    tick();
    m_a[1] = d17;
    idle_a();
    vra1 = 5'd17; vra2 = 5'd17;
    expect_at(RD1, "rd17_p1", m_a[1], 0);
    expect_at(RD2, "rd17_p2", m_a[1], 0);
    tick();

    // Masked write with same-cycle bypass: lanes 0 and 2 become all-ones
    upd17 = d17;
    upd17[0*32 +: 32] = 32'hFFFF_FFFF;
    upd17[2*32 +: 32] = 32'hFFFF_FFFF;
    wr_a(5'd17, '1, 8'h05);
    vra1 = 5'd17; vra2 = 5'd16;
    expect_at(RD1, "bypass17", upd17, 0);
    expect_at(RD2, "bypass_other", '0, 0);
    tick();
    m_a[1] = upd17;
    idle_a();
    vra1 = 5'd17;
    expect_at(RD1, "persist17", m_a[1], 0);
    tick();

    // Out-of-window writes are dropped and flagged
    wr_a(5'd5, {8{32'hDEAD_BEEF}}, 8'hFF);
    vra1 = 5'd5; vra2 = 5'd0;
    expect_at(RD1, "rd5_zero", '0, 0);
    expect_at(RD2, "rd0_zero", '0, 0);
    expect_at(DROP, "drop_wr5", 256'd1, 1);
    tick();
    wr_a(5'd24, {8{32'hDEAD_BEEF}}, 8'hFF);
    vra1 = 5'd24; vra2 = 5'd30;
    expect_at(RD1, "rd24_zero", '0, 0);
    expect_at(RD2, "rd30_zero", '0, 0);
    expect_at(DROP, "drop_wr24", 256'd1, 1);
    tick();
    idle_a();
    vra1 = 5'd17;
    expect_at(RD1, "rd17_after_drops", m_a[1], 0);
    expect_at(DROP, "drop_clears", '0, 1);
    tick();

    // Zero mask with write enable is a silent no-op
    wr_a(5'd17, '0, 8'h00);
    vra1 = 5'd17;
    expect_at(RD1, "mask0_bypass", m_a[1], 0);
    expect_at(DROP, "mask0_nodrop", '0, 1);
    tick();

    // Fill every register; full-mask bypass shows the new row immediately
    for (int r = 0; r < 8; r++) begin
      wr_a(5'(16 + r), fill(r), 8'hFF);
      vra1 = 5'(16 + r);
      expect_at(RD1, $sformatf("fill_byp%0d", r), fill(r), 0);
      tick();
      m_a[r] = fill(r);
    end

    // Clear request together with a write to 22: the write still commits
    wr_a(5'd22, fill(9), 8'hFF);
    clr_req = 1'b1;
    expect_at(BUSY, "busy_pre", '0, 0);
    expect_at(DROP, "wr22_clrreq_nodrop", '0, 1);
    tick();
    m_a[6] = fill(9);

    // Clear sequence: one row per cycle, in index order
    for (int k = 0; k < 8; k++) begin
      idle_a();
      clr_req = (k == 0);
      vra1 = 5'(16 + k);
      expect_at(RD1, $sformatf("clr%0d_row_old", k), m_a[k], 0);
      expect_at(BUSY, $sformatf("clr%0d_busy", k), 256'd1, 0);
      expect_at(DONE, $sformatf("clr%0d_done", k), '0, 0);
      if (k == 2) begin
        wr_a(5'd20, fill(10), 8'hFF);
        vra2 = 5'd20;
        expect_at(RD2, "clr_no_bypass", m_a[4], 0);
        expect_at(DROP, "clr_wr_drop", 256'd1, 1);
      end else if (k > 0) begin
        vra2 = 5'(16 + k - 1);
        expect_at(RD2, $sformatf("clr%0d_prev_zero", k), '0, 0);
      end
      tick();
      m_a[k] = '0;
    end

    // DONE cycle: write dropped, new request ignored
    idle_a();
    wr_a(5'd21, fill(11), 8'hFF);
    clr_req = 1'b1;
    vra1 = 5'd23;
    expect_at(RD1, "done_row7_zero", '0, 0);
    expect_at(BUSY, "done_busy", '0, 0);
    expect_at(DONE, "done_pulse", 256'd1, 0);
    expect_at(DROP, "done_wr_drop", 256'd1, 1);
    tick();
    idle_a();
    vra1 = 5'd21; vra2 = 5'd22;
    expect_at(RD1, "post_rd21", '0, 0);
    expect_at(RD2, "post_rd22", '0, 0);
    expect_at(BUSY, "post_busy", '0, 0);
    expect_at(DONE, "post_done", '0, 0);
    tick();
    vra1 = 5'd16; vra2 = 5'd20;
    expect_at(RD1, "post2_rd16", '0, 0);
    expect_at(RD2, "post2_rd20", '0, 0);
    expect_at(BUSY, "req_in_done_ignored", '0, 0);
    tick();

    // Reset in the middle of a clear sequence
    wr_a(5'd18, fill(3), 8'hFF);
    tick();
    m_a[2] = fill(3);
    wr_a(5'd23, fill(7), 8'hFF);
    tick();
    m_a[7] = fill(7);
    idle_a();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    vra1 = 5'd23; vra2 = 5'd18;
    expect_at(RD1, "mid_rd23_old", m_a[7], 0);
    expect_at(BUSY, "mid_busy", 256'd1, 0);
    #1 score();
    #2 rst = 1'b0;
    #1;
    expect_at(RD1, "arst_rd23", '0, 0);
    expect_at(RD2, "arst_rd18", '0, 0);
    expect_at(BUSY, "arst_busy", '0, 0);
    expect_at(DONE, "arst_done", '0, 0);
    score();
    next_edge();
    expect_at(BUSY, "arst_hold_busy", '0, 0);
    expect_at(DONE, "arst_hold_done", '0, 0);
    score();
    #2 rst = 1'b1;
    next_edge();
    for (int r = 0; r < 8; r++) m_a[r] = '0;
    expect_at(DONE, "arst_rel_done", '0, 0);
    wr_a(5'd18, fill(12), 8'hFF);
    tick();
    m_a[2] = fill(12);
    idle_a();
    vra1 = 5'd18; vra2 = 5'd23;
    expect_at(RD1, "arst_rd18_new", m_a[2], 0);
    expect_at(RD2, "arst_rd23_zero", '0, 0);
    expect_at(BUSY, "arst_after_busy", '0, 0);
    tick();

    // Small instance: window 8..11, 16-bit lanes, 4-cycle clear
    wr_b(5'd8, {4{16'hAAAA}}, 4'hF);
    expect_at(B_DROP, "b_wr8_nodrop", '0, 1);
    tick();
    wr_b(5'd11, {4{16'h1234}}, 4'hF);
    b_ra1 = 5'd11; b_ra2 = 5'd8;
    expect_at(B_RD1, "b_byp11", 256'h1234_1234_1234_1234, 0);
    expect_at(B_RD2, "b_rd8", 256'hAAAA_AAAA_AAAA_AAAA, 0);
    tick();
    wr_b(5'd12, {4{16'hBEEF}}, 4'hF);
    b_ra1 = 5'd12;
    expect_at(B_RD1, "b_rd12_zero", '0, 0);
    expect_at(B_DROP, "b_drop12", 256'd1, 1);
    tick();
    wr_b(5'd7, {4{16'hBEEF}}, 4'hF);
    b_ra1 = 5'd7;
    expect_at(B_RD1, "b_rd7_zero", '0, 0);
    expect_at(B_DROP, "b_drop7", 256'd1, 1);
    tick();
    wr_b(5'd8, {4{16'h5555}}, 4'h3);
    b_ra1 = 5'd8;
    expect_at(B_RD1, "b_mask3_byp", 256'hAAAA_AAAA_5555_5555, 0);
    tick();
    idle_b();
    b_ra1 = 5'd8; b_ra2 = 5'd11;
    expect_at(B_RD1, "b_mask3_keep", 256'hAAAA_AAAA_5555_5555, 0);
    expect_at(B_RD2, "b_rd11", 256'h1234_1234_1234_1234, 0);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_at(B_BUSY, $sformatf("b_clr%0d_busy", k), 256'd1, 0);
      expect_at(B_DONE, $sformatf("b_clr%0d_done", k), '0, 0);
      tick();
    end
    b_ra1 = 5'd8; b_ra2 = 5'd11;
    expect_at(B_BUSY, "b_done_busy", '0, 0);
    expect_at(B_DONE, "b_done_pulse", 256'd1, 0);
    expect_at(B_RD1, "b_rd8_clr", '0, 0);
    expect_at(B_RD2, "b_rd11_clr", '0, 0);
    tick();
    expect_at(B_DONE, "b_post_done", '0, 0);
    tick();

    // Any expectation never reached counts as a failure
    foreach (exp_q[i]) check({"unscored_", exp_q[i].tag}, 256'd1, 256'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_vec_banked.md
Name: regfile_vec_banked

Overview:
- Parametrised vector register file for the vector datapath.
- Configurable lane count, lane width, register count and architectural base index.
- Adds per-lane write masking, write-to-read bypass, out-of-range address protection and a multi-cycle bulk-clear sequencer with busy/done handshake.
- Sits between the vector decode stage (read addresses) and the vector writeback stage (write port).

Parameters:
- LANES, 8, number of lanes per vector register.
- LANE_W, 32, bits per lane; vector width VW = LANES*LANE_W.
- NREGS, 8, number of vector registers implemented.
- BASE, 16, architectural index of the first register; valid window is BASE..BASE+NREGS-1.
- ADDR_W, 5, register address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- vwe3  input  1  write enable.
- vwa3  input  ADDR_W  write address.
- vwd3  input  VW  write data; lane i = bits [i*LANE_W +: LANE_W].
- vwmask  input  LANES  per-lane write enable; bit i gates lane i.
- vra1  input  ADDR_W  read address, port 1.
- vra2  input  ADDR_W  read address, port 2.
- vrd1  output  VW  read data, port 1 (combinational).
- vrd2  output  VW  read data, port 2 (combinational).
- clr_req  input  1  request bulk clear of all registers.
- clr_busy  output  1  high while the clear sequence runs.
- clr_done  output  1  one-cycle pulse when the clear sequence completes.
- wr_drop  output  1  one-cycle pulse: an accepted-looking write was discarded.

Behaviour:
- Reset (rst=0, asynchronous): all registers 0, FSM=IDLE, clear index 0, clr_busy=0, clr_done=0, wr_drop=0. Reads during reset return 0.
- Address validity: valid(a) = (a != 0) && BASE <= a < BASE+NREGS. Storage row = a-BASE.
- Reads: vrdN = 0 if !valid(vraN). Otherwise vrdN = stored row, with a bypass applied as follows.
- Bypass: if vwe3 && valid(vwa3) && vwa3==vraN && FSM==IDLE, then per lane: lane i = vwmask[i] ? vwd3 lane i : stored lane i. Zero added latency; new data is visible in the same cycle.
- Write: on rising edge, if vwe3 && valid(vwa3) && FSM==IDLE, lanes with vwmask[i]=1 are updated. Other lanes hold their value.
  - vwmask=0 with vwe3=1 is a legal no-op; wr_drop is not asserted.
- wr_drop: registered pulse, high the cycle after any vwe3=1 whose write was discarded. Discard causes: invalid address, or FSM!=IDLE.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 -> CLEAR, idx=0, clr_busy=1 from the next cycle. A write in the same cycle as clr_req is committed, then cleared later.
  - CLEAR: each cycle row idx <= 0 and idx++. Takes exactly NREGS cycles. When idx==NREGS-1 -> DONE. clr_req is ignored while in CLEAR.
  - DONE: one cycle; clr_done=1, clr_busy=0 -> IDLE. A clr_req during DONE is ignored; a new request is accepted from IDLE.
- During CLEAR/DONE: reads return current storage contents (cleared rows read 0, uncleared rows read old data). No bypass. All writes are dropped and flagged via wr_drop.
- Reset mid-CLEAR: immediate return to IDLE; all rows 0; no clr_done pulse.
- Both read ports may address the same register. Same-address read and write behave per the bypass rule.
- All arithmetic is unsigned. idx width = clog2(NREGS), minimum 1.

Test Plan:
- Reset then read 16 and 23 -> vrd1=vrd2=0, clr_busy=0.
- Write vwa3=17, vwd3 lanes=0x11111111*i, vwmask=0xFF; next cycle read 17 -> all lanes match. Then write 17 with 0xFFFFFFFF, vwmask=0x05, reading vra1=17 in the same cycle -> bypass shows lanes 0 and 2 = 0xFFFFFFFF, others old. Persists next cycle.
- Write vwa3=5 and vwa3=24 -> storage unchanged, wr_drop pulses one cycle after each; vra1=0 and vra1=30 read 0.
- Fill all 8 regs, pulse clr_req -> clr_busy high exactly 8 cycles, rows zeroed in index order (row 3 reads 0 after 4th CLEAR cycle, row 4 still old), clr_done one pulse, clr_busy=0; writes to 20 during CLEAR -> dropped, wr_drop=1.
- Assert rst=0 asynchronously (between edges) in CLEAR cycle 3 -> outputs 0 immediately, no clr_done; after release, write/read 18 works normally.
- Re-parameterise LANES=4, LANE_W=16, NREGS=4, BASE=8 -> valid 8..11 only; clear takes 4 cycles; masked write 0x3 updates low 32 bits only.
